display_scan_controller: RTL and testbench

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

---
 rtl/display_scan_controller_pkg.sv | 26 ++
 rtl/display_scan_controller_if.sv | 39 +++
 rtl/display_scan_controller_period_counter.sv | 39 +++
 rtl/display_scan_controller.sv | 153 +++++++++++++++
 tb/tb_display_scan_controller.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/display_scan_controller_pkg.sv
// -----------------------------------------------------------------------------
// display_scan_controller_pkg
// Shared definitions for the 4-digit display scan controller:
//   - FSM state encoding (IDLE / SHOW / BLANK)
//   - ANODE_OFF: all anodes dark (active-low enables)
//   - cnt_width(): cycle-counter width for a given PRESCALE / BLANK_CYCLES pair
// -----------------------------------------------------------------------------
package display_scan_controller_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHOW  = 2'd1;
    localparam logic [1:0] ST_BLANK = 2'd2;

    localparam logic [3:0] ANODE_OFF = 4'b1111;

    // Wide enough to hold PRESCALE-1 and BLANK_CYCLES-1; never below 1 bit.
    function automatic int cnt_width(input int prescale, input int blank_cycles);
        int longest;
        longest = (prescale > blank_cycles) ? prescale : blank_cycles;
        if (longest < 2) begin
            longest = 2;
        end
        return $clog2(longest);
    endfunction

endpackage

// File: rtl/display_scan_controller_if.sv
// -----------------------------------------------------------------------------
// display_scan_if
// Control/scan bundle between a display driver (master) and the scan
// controller (slave).
//   en          master->slave  scan enable, 0 = display off
//   blank_mask  master->slave  bit k = 1 keeps digit k dark
//   sel         slave->master  4:1 digit mux select (sel[1]=s1, sel[0]=s0)
//   an          slave->master  active-low anode enables
//   scan_tick   slave->master  one-cycle pulse per digit advance
//   frame_done  slave->master  one-cycle pulse when sel wraps 3->0
// -----------------------------------------------------------------------------
interface display_scan_if;

    logic       en;
    logic [3:0] blank_mask;
    logic [1:0] sel;
    logic [3:0] an;
    logic       scan_tick;
    logic       frame_done;

    modport master (
        output en,
        output blank_mask,
        input  sel,
        input  an,
        input  scan_tick,
        input  frame_done
    );

    modport slave (
        input  en,
        input  blank_mask,
        output sel,
        output an,
        output scan_tick,
        output frame_done
    );

endinterface

// File: rtl/display_scan_controller_period_counter.sv
// -----------------------------------------------------------------------------
// period_counter
// Free-running cycle counter with a run-time terminal count. Counts
// 0..i_tc_value and wraps to 0 on the cycle after o_tc; i_clear forces 0 and
// wins over i_enable.
//   clk, rst_n   clock, asynchronous active-low reset
//   i_clear      synchronous clear
//   i_enable     advance the count
//   i_tc_value   terminal count (last value before wrap)
//   o_tc         high while the count equals i_tc_value
// -----------------------------------------------------------------------------
module period_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_tc_value,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    assign o_tc = (r_count == i_tc_value);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= o_tc ? '0 : r_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// -----------------------------------------------------------------------------
// display_scan_controller
// Time-multiplexes a 4-digit common-anode display. Each digit is lit for
// PRESCALE cycles, followed by BLANK_CYCLES dark cycles while the external
// mux settles on the next digit. All outputs are registered.
//   PRESCALE      cycles each digit is shown (>= 2)
//   BLANK_CYCLES  dark cycles between digits (0 disables blanking)
//   clk, rst_n    clock, asynchronous active-low reset
//   scan          display_scan_if.slave (en, blank_mask in; sel, an,
//                 scan_tick, frame_done out)
// -----------------------------------------------------------------------------
module display_scan_controller
    import display_scan_controller_pkg::*;
#(
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic          clk,
    input  logic          rst_n,
    display_scan_if.slave scan
);

    localparam int CNT_W = cnt_width(PRESCALE, BLANK_CYCLES);
    localparam logic [CNT_W-1:0] SHOW_TC  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_TC = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    // Active-low anode for the selected digit unless it is masked dark.
    function automatic logic [3:0] anode_for(input logic [1:0] sel, input logic [3:0] mask);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << sel;
        return mask[sel] ? ANODE_OFF : ~one_hot;
    endfunction

    // NOTE: reset asserts asynchronously but releases through two flops, so
    // the FSM only starts once r_run has been clocked in cleanly.
    logic r_sync_meta;
    logic r_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_meta <= 1'b0;
            r_run       <= 1'b0;
        end else begin
            r_sync_meta <= 1'b1;
            r_run       <= r_sync_meta;
        end
    end

    logic [1:0] r_state;
    logic [1:0] r_sel;
    logic [3:0] r_an;
    logic       r_scan_tick;
    logic       r_frame_done;

    logic       w_tc;
    logic       w_cnt_clear;
    logic [CNT_W-1:0] w_tc_value;

    // The counter wraps by itself on terminal count, which is exactly the
    // SHOW<->BLANK boundary; it only needs an explicit clear when not scanning.
    assign w_cnt_clear = !r_run || !scan.en || (r_state == ST_IDLE);
    assign w_tc_value  = (r_state == ST_BLANK) ? BLANK_TC : SHOW_TC;

    period_counter #(
        .WIDTH (CNT_W)
    ) u_period_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_cnt_clear),
        .i_enable   (1'b1),
        .i_tc_value (w_tc_value),
        .o_tc       (w_tc)
    );

    logic [1:0] w_state_nxt;
    logic [1:0] w_sel_nxt;
    logic [3:0] w_an_nxt;
    logic       w_tick_nxt;
    logic       w_frame_nxt;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_an_nxt    = ANODE_OFF;
        w_tick_nxt  = 1'b0;
        w_frame_nxt = 1'b0;

        if (!r_run || !scan.en) begin
            // Disable wins over terminal count: no pulse, restart at digit 0.
            w_state_nxt = ST_IDLE;
            w_sel_nxt   = 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_SHOW;
                    w_sel_nxt   = 2'd0;
                    w_an_nxt    = anode_for(2'd0, scan.blank_mask);
                end
                ST_SHOW: begin
                    if (w_tc) begin
                        w_sel_nxt   = r_sel + 2'd1;
                        w_tick_nxt  = 1'b1;
                        w_frame_nxt = (r_sel == 2'd3);
                        if (BLANK_CYCLES == 0) begin
                            w_state_nxt = ST_SHOW;
                            w_an_nxt    = anode_for(r_sel + 2'd1, scan.blank_mask);
                        end else begin
                            w_state_nxt = ST_BLANK;
                        end
                    end else begin
                        w_an_nxt = anode_for(r_sel, scan.blank_mask);
                    end
                end
                ST_BLANK: begin
                    // sel already points at the next digit; light it once the
                    // dark interval ends.
                    if (w_tc) begin
                        w_state_nxt = ST_SHOW;
                        w_an_nxt    = anode_for(r_sel, scan.blank_mask);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_sel_nxt   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_sel        <= 2'd0;
            r_an         <= ANODE_OFF;
            r_scan_tick  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sel        <= w_sel_nxt;
            r_an         <= w_an_nxt;
            r_scan_tick  <= w_tick_nxt;
            r_frame_done <= w_frame_nxt;
        end
    end

    assign scan.sel        = r_sel;
    assign scan.an         = r_an;
    assign scan.scan_tick  = r_scan_tick;
    assign scan.frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_display_scan_controller
// Two controllers share one stimulus: dut_a (PRESCALE=4, BLANK_CYCLES=2) and
// dut_b (PRESCALE=4, BLANK_CYCLES=0). A behavioural model tracks each one as
// (on, digit, position within the digit period) and is compared on every
// falling edge; literal traces pin the model at known points.
// -----------------------------------------------------------------------------
module tb_display_scan_controller;

    typedef struct packed {
        logic       on;
        int         digit;
        int         t;       // cycle index inside the digit period
        logic       tick;
        logic       fd;
        logic [3:0] an;
    } mstate_t;

    localparam mstate_t M_RESET = '{on: 1'b0, digit: 0, t: 0, tick: 1'b0, fd: 1'b0, an: 4'hF};

    logic       clk = 1'b0;
    logic       clk_en = 1'b1;
    logic       rst_n = 1'b0;
    logic       tb_en = 1'b0;
    logic [3:0] tb_mask = 4'h0;

    int checks = 0;
    int failures = 0;

    mstate_t m_a = M_RESET;
    mstate_t m_b = M_RESET;
    int      rel_edges = 0;

    display_scan_if if_a ();
    display_scan_if if_b ();

    assign if_a.en         = tb_en;
    assign if_a.blank_mask = tb_mask;
    assign if_b.en         = tb_en;
    assign if_b.blank_mask = tb_mask;

    display_scan_controller #(.PRESCALE(4), .BLANK_CYCLES(2)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .scan  (if_a)
    );

    display_scan_controller #(.PRESCALE(4), .BLANK_CYCLES(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .scan  (if_b)
    );

    initial begin
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // One edge of the display as seen from its rules: a digit period is
    // p lit cycles then b dark cycles; the digit advances entering the dark part.
    function automatic mstate_t step(input mstate_t m, input int p, input int b,
                                     input bit armed, input logic en_s, input logic [3:0] mask_s);
        mstate_t    n;
        logic [3:0] one_hot;
        n = m;
        n.tick = 1'b0;
        n.fd   = 1'b0;
        if (armed) begin
            if (!en_s) begin
                n.on = 1'b0; n.digit = 0; n.t = 0;
            end else if (!m.on) begin
                n.on = 1'b1; n.digit = 0; n.t = 0;
            end else begin
                n.t = m.t + 1;
                if (n.t == p) begin
                    n.tick  = 1'b1;
                    n.fd    = (m.digit == 3);
                    n.digit = (m.digit + 1) % 4;
                end
                if (n.t == p + b) n.t = 0;
            end
        end
        one_hot = 4'b0001 << n.digit;
        n.an = (!n.on || n.t >= p || mask_s[n.digit]) ? 4'hF : ~one_hot;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a       <= M_RESET;
            m_b       <= M_RESET;
            rel_edges <= 0;
        end else begin
            m_a <= step(m_a, 4, 2, rel_edges >= 2, tb_en, tb_mask);
            m_b <= step(m_b, 4, 0, rel_edges >= 2, tb_en, tb_mask);
            if (rel_edges < 2) rel_edges <= rel_edges + 1;
        end
    end

    task automatic cmp_model(input string tag, input logic [1:0] sel, input logic [3:0] an,
                             input logic tk, input logic fd, input mstate_t m);
        check({tag, "_sel"}, sel, m.digit[1:0]);
        check({tag, "_an"}, an, m.an);
        check({tag, "_scan_tick"}, tk, m.tick);
        check({tag, "_frame_done"}, fd, m.fd);
        check({tag, "_an_one_low"}, ($countones(~an) <= 1), 1);
    endtask

    always @(negedge clk) begin
        cmp_model("a", if_a.sel, if_a.an, if_a.scan_tick, if_a.frame_done, m_a);
        cmp_model("b", if_b.sel, if_b.an, if_b.scan_tick, if_b.frame_done, m_b);
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [95:0] lit_an_a;
    logic [95:0] lit_sel_a;
    logic [23:0] lit_tick_a;
    logic [95:0] lit_an_b;
    logic [23:0] lit_tick_b;
    int          seen2;
    int          n;

    initial begin
        lit_an_a   = 96'hEEEEFFDDDDFFBBBBFF7777FF;
        lit_sel_a  = 96'h000011111122222233333300;
        lit_tick_a = 24'b0;
        lit_tick_a[4] = 1'b1; lit_tick_a[10] = 1'b1; lit_tick_a[16] = 1'b1; lit_tick_a[22] = 1'b1;
        lit_an_b   = 96'hEEEEDDDDBBBB7777EEEEDDDD;
        lit_tick_b = 24'b0;
        lit_tick_b[4] = 1'b1; lit_tick_b[8] = 1'b1; lit_tick_b[12] = 1'b1;
        lit_tick_b[16] = 1'b1; lit_tick_b[20] = 1'b1;

        // Reset state with clock running.
        repeat (3) @(negedge clk);
        check("rst_sel", if_a.sel, 2'd0);
        check("rst_an", if_a.an, 4'hF);
        check("rst_pulses", {if_a.scan_tick, if_a.frame_done}, 2'b00);

        // Release with en already high: still dark after two edges.
        #1; rst_n = 1'b1; tb_en = 1'b1;
        @(negedge clk); check("release_edge1_an", if_a.an, 4'hF);
        @(negedge clk); check("release_edge2_an", if_a.an, 4'hF);

        // One full frame of dut_a, 24 cycles; dut_b with no blanking.
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            check("trace_a_an", if_a.an, lit_an_a[95 - 4*i -: 4]);
            check("trace_a_sel", if_a.sel, lit_sel_a[95 - 4*i -: 4]);
            check("trace_a_tick", if_a.scan_tick, lit_tick_a[i]);
            check("trace_a_fd", if_a.frame_done, (i == 22));
            check("trace_b_an", if_b.an, lit_an_b[95 - 4*i -: 4]);
            check("trace_b_tick", if_b.scan_tick, lit_tick_b[i]);
            check("trace_b_fd", if_b.frame_done, (i == 16));
        end

        // Digit 2 masked: dark for its whole slot, sel still steps.
        #1; tb_mask = 4'b0100;
        seen2 = 0;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (if_a.sel == 2'd2) begin
                seen2++;
                check("mask_digit2_dark", if_a.an, 4'hF);
            end
        end
        check("mask_digit2_slot_len", seen2, 6);
        #1; tb_mask = 4'b0000;

        // en dropped while digit 2 is lit.
        for (n = 0; n < 60 && !(if_a.sel == 2'd2 && if_a.an == 4'hB); n++) @(negedge clk);
        check("wait_digit2_lit", (if_a.sel == 2'd2 && if_a.an == 4'hB), 1);
        #1; tb_en = 1'b0;
        @(negedge clk);
        check("drop_an", if_a.an, 4'hF);
        check("drop_sel", if_a.sel, 2'd0);
        check("drop_pulses", {if_a.scan_tick, if_a.frame_done}, 2'b00);
        #1; tb_en = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("reenable_an", if_a.an, 4'hE);
        end
        @(negedge clk);
        check("reenable_blank_an", if_a.an, 4'hF);
        check("reenable_blank_sel", if_a.sel, 2'd1);

        // en dropped exactly at the terminal count of digit 3.
        for (n = 0; n < 60 && !(m_a.on && m_a.digit == 3 && m_a.t == 3); n++) @(negedge clk);
        check("wait_digit3_last", (if_a.sel == 2'd3 && if_a.an == 4'h7), 1);
        #1; tb_en = 1'b0;
        @(negedge clk);
        check("tc_drop_tick", if_a.scan_tick, 1'b0);
        check("tc_drop_fd", if_a.frame_done, 1'b0);
        check("tc_drop_sel", if_a.sel, 2'd0);
        check("tc_drop_an", if_a.an, 4'hF);
        #1; tb_en = 1'b1;

        // Randomised en / mask / asynchronous reset traffic.
        for (int k = 0; k < 900; k++) begin
            int r;
            @(negedge clk);
            #1;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                #2; rst_n = 1'b0;
                tb_en = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 3)) @(negedge clk);
                #2; rst_n = 1'b1;
            end else if (r < 6) begin
                tb_en = ~tb_en;
            end else if (r < 18) begin
                tb_mask = 4'($urandom_range(0, 15));
            end
            if (!tb_en && $urandom_range(0, 9) == 0) tb_en = 1'b1;
        end

        // Reset with the clock stopped, mid-frame.
        #1; tb_en = 1'b1; tb_mask = 4'h0;
        for (n = 0; n < 60 && if_a.sel != 2'd2; n++) @(negedge clk);
        check("wait_sel2_for_stop", if_a.sel, 2'd2);
        @(negedge clk);
        clk_en = 1'b0;
        #3; rst_n = 1'b0;
        #1;
        check("stopped_rst_sel_a", if_a.sel, 2'd0);
        check("stopped_rst_an_a", if_a.an, 4'hF);
        check("stopped_rst_pulses_a", {if_a.scan_tick, if_a.frame_done}, 2'b00);
        check("stopped_rst_an_b", if_b.an, 4'hF);
        check("stopped_rst_sel_b", if_b.sel, 2'd0);
        #10; rst_n = 1'b1;
        #2; clk_en = 1'b1;
        @(negedge clk); check("restart_edge1_an", if_a.an, 4'hF);
        @(negedge clk); check("restart_edge2_an", if_a.an, 4'hF);
        @(negedge clk); check("restart_digit0_an", if_a.an, 4'hE);
        check("restart_digit0_sel", if_a.sel, 2'd0);
        repeat (30) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
